// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Responder side of the instruction-fetch interface. Holds a word-addressed
// instruction store (preloaded through a load port) and answers one fetch
// request at a time after a fixed LATENCY, using valid/ready handshakes.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-low reset (memory array is not cleared)
//   req_valid_i  fetch request present (held by requester until accepted)
//   req_addr_i   byte address of the requested instruction
//   req_ready_o  responder can accept a request this cycle (IDLE only)
//   rsp_valid_o  response present
//   rsp_instr_o  fetched instruction (NOP_INSTR on error)
//   rsp_err_o    request was misaligned or out of range
//   rsp_ready_i  requester accepts the response this cycle
//   ld_we_i      load-port write enable
//   ld_addr_i    load-port byte address (bits [1:0] ignored)
//   ld_data_i    load-port write data
//   fetch_cnt_o  count of completed response handshakes (wraps)
//
// CNT_RESET_VAL is the value fetch_cnt_o takes in reset; it is 0 for normal
// use and only differs when a counter preset is wanted.
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned LATENCY       = 2,
    parameter logic [31:0] NOP_INSTR     = 32'h00000013,
    parameter logic [15:0] CNT_RESET_VAL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_err_o,
    input  logic        rsp_ready_i,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i,
    output logic [15:0] fetch_cnt_o
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_instr;
    logic        r_rsp_err;
    logic [15:0] r_fetch_cnt;

    logic [29:0] w_req_idx;
    logic        w_req_err;
    logic [31:0] w_rd_data;
    logic        w_accept;
    logic        w_ld_ok;
    logic        w_unused_ok;

    assign w_req_idx = req_addr_i[31:2];
    // Misaligned or beyond the store: answered with NOP and the error flag.
    assign w_req_err = (req_addr_i[1:0] != 2'b00) || (w_req_idx >= 30'(DEPTH));
    assign w_rd_data = r_mem[w_req_idx[AW-1:0]];
    // r_req_ready is only ever set while in IDLE; the state term is a guard.
    assign w_accept  = r_req_ready && req_valid_i && (r_state == ST_IDLE);
    assign w_ld_ok   = ld_we_i && (ld_addr_i[31:2] < 30'(DEPTH));
    // Byte-offset bits of the load address are intentionally ignored.
    assign w_unused_ok = &{1'b0, ld_addr_i[1:0]};

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_instr_o = r_rsp_instr;
    assign rsp_err_o   = r_rsp_err;
    assign fetch_cnt_o = r_fetch_cnt;

    // Instruction store write port; the read at an accept edge samples the
    // old contents, so a same-edge load and accept return the previous word.
    always_ff @(posedge clk_i) begin
        if (w_ld_ok) begin
            r_mem[ld_addr_i[AW+1:2]] <= ld_data_i;
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_fetch_cnt <= CNT_RESET_VAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_rsp_err   <= w_req_err;
                        r_rsp_instr <= w_req_err ? NOP_INSTR : w_rd_data;
                        if (LATENCY <= 1) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        r_req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_req_ready <= 1'b0;
                    if (r_cnt <= 4'd1) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_fetch_cnt <= r_fetch_cnt + 16'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cnt       <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

    localparam int          DEPTH      = 32;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [15:0] B_CNT_INIT = 16'hFFF0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        sel;   // 0: LATENCY=2 instance, 1: LATENCY=1 instance

    logic        a_ready, a_valid, a_err, b_ready, b_valid, b_err;
    logic [31:0] a_instr, b_instr;
    logic [15:0] a_cnt, b_cnt;

    imem_fetch_responder #(.DEPTH(32), .LATENCY(2), .NOP_INSTR(32'h00000013)) dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid & ~sel), .req_addr_i(req_addr), .req_ready_o(a_ready),
        .rsp_valid_o(a_valid), .rsp_instr_o(a_instr), .rsp_err_o(a_err), .rsp_ready_i(rsp_ready),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .fetch_cnt_o(a_cnt)
    );

    imem_fetch_responder #(.DEPTH(32), .LATENCY(1), .NOP_INSTR(32'h00000013),
                           .CNT_RESET_VAL(16'hFFF0)) dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid & sel), .req_addr_i(req_addr), .req_ready_o(b_ready),
        .rsp_valid_o(b_valid), .rsp_instr_o(b_instr), .rsp_err_o(b_err), .rsp_ready_i(rsp_ready),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .fetch_cnt_o(b_cnt)
    );

    logic        w_ready, w_valid, w_err;
    logic [31:0] w_instr;
    logic [15:0] w_cnt;
    assign w_ready = sel ? b_ready : a_ready;
    assign w_valid = sel ? b_valid : a_valid;
    assign w_err   = sel ? b_err   : a_err;
    assign w_instr = sel ? b_instr : a_instr;
    assign w_cnt   = sel ? b_cnt   : a_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [15:0] model_cnt_a, model_cnt_b;

    // Reference rules: misaligned or word index >= DEPTH is an error.
    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        if (exp_err(a)) return NOP;
        return model_mem[int'(a >> 2)];
    endfunction

    function automatic logic [15:0] model_cnt();
        return sel ? model_cnt_b : model_cnt_a;
    endfunction

    task automatic bump_cnt();
        if (sel) model_cnt_b = model_cnt_b + 16'd1;
        else     model_cnt_a = model_cnt_a + 16'd1;
    endtask

    task automatic model_load(input logic [31:0] a, input logic [31:0] d);
        if ((a >> 2) < 32'(DEPTH)) model_mem[int'(a >> 2)] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_we = 1'b0;
        model_load(a, d);
    endtask

    // One complete fetch on the selected instance with optional backpressure,
    // a load to the same word at the accept edge, or a load while waiting.
    task automatic do_fetch(input logic [31:0] addr, input int stall,
                            input bit ld_acc, input logic [31:0] acc_data, input bit ld_mid);
        logic [31:0] ei;
        logic        ee;
        logic [31:0] md;
        int          k;
        int          lat;
        int          exp_lat;
        ei = exp_instr(addr);
        ee = exp_err(addr);
        exp_lat = sel ? 1 : 2;
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_addr  = addr;
        k = 0;
        while (!w_ready && k < 40) begin step(); k++; end
        if (!w_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h ready=%b expected 1", addr, w_ready);
            req_valid = 1'b0;
            return;
        end
        if (ld_acc) begin ld_we = 1'b1; ld_addr = addr; ld_data = acc_data; end
        step();
        req_valid = 1'b0;
        ld_we = 1'b0;
        if (ld_acc) model_load(addr, acc_data);
        checks++;
        if (w_ready !== 1'b0) begin
            errors++; $display("FAIL ready_after_accept got %b expected 0", w_ready);
        end
        lat = 1;
        while (!w_valid && lat < 40) begin
            if (ld_mid && lat == 1) begin
                md = $urandom;
                ld_we = 1'b1; ld_addr = {addr[31:2], 2'b00}; ld_data = md;
                model_load(addr, md);
            end
            step();
            ld_we = 1'b0;
            lat++;
        end
        checks++;
        if (w_valid !== 1'b1 || lat != exp_lat) begin
            errors++; $display("FAIL latency addr=%h got %0d valid=%b expected %0d", addr, lat, w_valid, exp_lat);
        end
        checks++;
        if (w_instr !== ei || w_err !== ee) begin
            errors++; $display("FAIL response addr=%h got %h/%b expected %h/%b", addr, w_instr, w_err, ei, ee);
        end
        for (int s = 0; s < stall; s++) begin
            step();
            checks++;
            if (w_valid !== 1'b1 || w_instr !== ei || w_err !== ee || w_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc=%0d got v=%b i=%h e=%b r=%b expected v=1 i=%h e=%b r=0",
                         s, w_valid, w_instr, w_err, w_ready, ei, ee);
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        bump_cnt();
        checks++;
        if (w_valid !== 1'b0 || w_ready !== 1'b1 || w_cnt !== model_cnt()) begin
            errors++;
            $display("FAIL handshake got v=%b r=%b cnt=%h expected v=0 r=1 cnt=%h",
                     w_valid, w_ready, w_cnt, model_cnt());
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0;
        rsp_ready = 1'b0; ld_we = 1'b0; ld_addr = 32'd0; ld_data = 32'd0;
        model_cnt_a = 16'h0000; model_cnt_b = B_CNT_INIT;
        step(); step();
        checks++;
        if (a_ready !== 1'b0 || a_valid !== 1'b0 || a_instr !== 32'd0 || a_err !== 1'b0 || a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got r=%b v=%b i=%h e=%b c=%h expected 0/0/0/0/0",
                     a_ready, a_valid, a_instr, a_err, a_cnt);
        end
        checks++;
        if (b_cnt !== B_CNT_INIT || b_valid !== 1'b0) begin
            errors++; $display("FAIL reset_b got c=%h v=%b expected %h/0", b_cnt, b_valid, B_CNT_INIT);
        end
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_release got %b expected 1", a_ready);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) load_word(32'(i) << 2, $urandom);
        load_word(32'h0, 32'h00500093);
        load_word(32'h4, 32'h00A00113);
    endtask

    task automatic test_basic();
        do_fetch(32'h0, 0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h4, 0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (w_cnt !== 16'd2) begin
            errors++; $display("FAIL basic_count got %0d expected 2", w_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_fetch(32'h4, 5, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_errors();
        do_fetch(32'h2, 0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'd128, 0, 1'b0, 32'h0, 1'b0);
        load_word(32'd128, 32'hDEADBEEF);
        for (int i = 0; i < DEPTH; i++) do_fetch(32'(i) << 2, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_same_edge();
        load_word(32'd12, 32'hAAAA_0001);
        do_fetch(32'd12, 0, 1'b1, 32'hBBBB_0002, 1'b0);
        do_fetch(32'd12, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int k;
        req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
        k = 0;
        while (!w_ready && k < 20) begin step(); k++; end
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_cnt !== 16'd0 || a_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_wait got v=%b c=%h r=%b expected 0/0/0", a_valid, a_cnt, a_ready);
        end
        step();
        rst_n = 1'b1;
        model_cnt_a = 16'h0000; model_cnt_b = B_CNT_INIT;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (a_valid !== 1'b0) begin
                errors++; $display("FAIL stale_response got %b expected 0", a_valid);
            end
        end
        req_valid = 1'b1;
        k = 0;
        while (!w_ready && k < 20) begin step(); k++; end
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (a_valid !== 1'b1) begin
            errors++; $display("FAIL resp_before_reset got %b expected 1", a_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_instr !== 32'd0 || a_err !== 1'b0) begin
            errors++; $display("FAIL reset_in_resp got v=%b i=%h e=%b expected 0/0/0", a_valid, a_instr, a_err);
        end
        step();
        rst_n = 1'b1;
        step(); step();
        do_fetch(32'h0, 0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (model_mem[0] !== 32'h00500093 || a_cnt !== 16'd1) begin
            errors++; $display("FAIL after_reset got mem0=%h cnt=%0d expected 00500093/1", model_mem[0], a_cnt);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                2:       addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                default: addr = 32'($urandom_range(DEPTH, 5000)) << 2;
            endcase
            do_fetch(addr, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        int period;
        int prev;
        int hs;
        int k;
        period = sel ? 2 : 3;
        prev = -1; hs = 0;
        rsp_ready = 1'b1; req_addr = 32'h4; req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (w_valid) begin
                checks++;
                if (w_instr !== exp_instr(32'h4)) begin
                    errors++; $display("FAIL b2b_data got %h expected %h", w_instr, exp_instr(32'h4));
                end
                if (prev >= 0) begin
                    checks++;
                    if (c - prev != period) begin
                        errors++; $display("FAIL b2b_period got %0d expected %0d", c - prev, period);
                    end
                end
                prev = c; hs++;
                bump_cnt();
            end
        end
        req_valid = 1'b0;
        k = 0;
        while (!w_ready && k < 10) begin
            step();
            if (w_valid) begin hs++; bump_cnt(); end
            k++;
        end
        step();
        rsp_ready = 1'b0;
        checks++;
        if (hs < 30 / period - 1 || w_cnt !== model_cnt()) begin
            errors++; $display("FAIL b2b_count got hs=%0d cnt=%h expected hs>=%0d cnt=%h",
                               hs, w_cnt, 30 / period - 1, model_cnt());
        end
    endtask

    task automatic test_latency1_wrap();
        bit wrap_seen;
        wrap_seen = 1'b0;
        sel = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            logic was_max;
            was_max = (model_cnt_b == 16'hFFFF);
            do_fetch(32'($urandom_range(0, DEPTH)) << 2, $urandom_range(0, 1), 1'b0, 32'h0, 1'b0);
            if (was_max) begin
                wrap_seen = 1'b1;
                checks++;
                if (b_cnt !== 16'h0000) begin
                    errors++; $display("FAIL cnt_wrap got %h expected 0000", b_cnt);
                end
            end
        end
        checks++;
        if (!wrap_seen) begin
            errors++; $display("FAIL wrap_reached got 0 expected 1");
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_backpressure();
        test_errors();
        test_same_edge();
        test_reset_mid();
        test_random(30);
        test_back_to_back();
        test_latency1_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
